// File: rtl/ram16k_fill.sv
// ram16k_fill: bulk-fill engine sitting in front of a 16K x 16 RAM.
// Writes a constant or incrementing pattern into a wrapping address range,
// one word per clock, and pulses done when finished.
// Optional read-back check is built when RAM16K_FILL_VERIFY_EN is defined.
//
// state  | meaning
// IDLE   | waiting for start; RAM outputs held at 0
// FILL   | writing one word per clock
// VERIFY | reading back and comparing one word per clock (macro only)

module ram16k_fill (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [13:0] base,
    input  logic [14:0] count,
    input  logic [15:0] value,
    input  logic        incr,
    input  logic [15:0] ram_out,
    output logic [15:0] ram_in,
    output logic [13:0] ram_address,
    output logic        ram_load,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [13:0] err_address
);

`ifdef RAM16K_FILL_VERIFY_EN
    typedef enum logic [1:0] {IDLE, FILL, VERIFY} state_t;
`else
    typedef enum logic [1:0] {IDLE, FILL} state_t;
`endif

    state_t      state_q, state_d;
    logic [14:0] rem_q, rem_d;
    logic [13:0] addr_q, addr_d;
    logic [15:0] data_q, data_d;
    logic        incr_q, incr_d;
    logic        load_q, load_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    // Anything at or above 16384 means the whole space, so bit 14 alone decides.
    logic [14:0] sat_count;
    assign sat_count = count[14] ? 15'd16384 : count;

`ifdef RAM16K_FILL_VERIFY_EN
    logic [13:0] base_q, base_d;
    logic [15:0] value_q, value_d;
    logic [14:0] len_m1_q, len_m1_d;
    logic        err_q, err_d;
    logic [13:0] erra_q, erra_d;
`endif

    // State and output registers; reset drops ram_load at once so no write can slip through.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            rem_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            incr_q  <= 1'b0;
            load_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            incr_q  <= incr_d;
            load_q  <= load_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

`ifdef RAM16K_FILL_VERIFY_EN
    // Job parameters needed to restart the address/data walk for read-back, plus error flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            base_q   <= '0;
            value_q  <= '0;
            len_m1_q <= '0;
            err_q    <= 1'b0;
            erra_q   <= '0;
        end else begin
            base_q   <= base_d;
            value_q  <= value_d;
            len_m1_q <= len_m1_d;
            err_q    <= err_d;
            erra_q   <= erra_d;
        end
    end
`endif

    // Next-state and next-output logic; rem is a down-counter reaching 0 on the last word.
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        addr_d  = addr_q;
        data_d  = data_q;
        incr_d  = incr_q;
        load_d  = load_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
`ifdef RAM16K_FILL_VERIFY_EN
        base_d   = base_q;
        value_d  = value_q;
        len_m1_d = len_m1_q;
        err_d    = err_q;
        erra_d   = erra_q;
`endif
        case (state_q)
            IDLE: begin
                load_d = 1'b0;
                busy_d = 1'b0;
                addr_d = '0;
                data_d = '0;
                if (start) begin
                    incr_d = incr;
`ifdef RAM16K_FILL_VERIFY_EN
                    base_d   = base;
                    value_d  = value;
                    len_m1_d = sat_count - 15'd1;
                    err_d    = 1'b0;
                    erra_d   = '0;
`endif
                    if (sat_count != 15'd0) begin
                        state_d = FILL;
                        rem_d   = sat_count - 15'd1;
                        addr_d  = base;
                        data_d  = value;
                        load_d  = 1'b1;
                        busy_d  = 1'b1;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            FILL: begin
                if (rem_q == 15'd0) begin
`ifdef RAM16K_FILL_VERIFY_EN
                    state_d = VERIFY;
                    rem_d   = len_m1_q;
                    addr_d  = base_q;
                    data_d  = value_q;
                    load_d  = 1'b0;
`else
                    state_d = IDLE;
                    addr_d  = '0;
                    data_d  = '0;
                    load_d  = 1'b0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
`endif
                end else begin
                    rem_d  = rem_q - 15'd1;
                    addr_d = addr_q + 14'd1;
                    data_d = data_q + {15'd0, incr_q};
                end
            end
`ifdef RAM16K_FILL_VERIFY_EN
            VERIFY: begin
                // Only the first mismatch of a job is recorded.
                if ((ram_out != data_q) && !err_q) begin
                    err_d  = 1'b1;
                    erra_d = addr_q;
                end
                if (rem_q == 15'd0) begin
                    state_d = IDLE;
                    addr_d  = '0;
                    data_d  = '0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    rem_d  = rem_q - 15'd1;
                    addr_d = addr_q + 14'd1;
                    data_d = data_q + {15'd0, incr_q};
                end
            end
`endif
            default: begin
                state_d = IDLE;
                load_d  = 1'b0;
                busy_d  = 1'b0;
                addr_d  = '0;
                data_d  = '0;
            end
        endcase
    end

    assign ram_in      = data_q;
    assign ram_address = addr_q;
    assign ram_load    = load_q;
    assign busy        = busy_q;
    assign done        = done_q;

`ifdef RAM16K_FILL_VERIFY_EN
    assign error       = err_q;
    assign err_address = erra_q;
`else
    logic unused_ram_out;
    assign unused_ram_out = ^ram_out;
    assign error       = 1'b0;
    assign err_address = '0;
`endif

endmodule
